// File: rtl/btn_pkg.sv
// Shared types and width helpers for the pushbutton conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the value v (at least one).
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce FSM, auto-repeat timer and
// registered level/press/release outputs.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] REP_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    btn_state_e             state_q, state_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0]       rpt_q, rpt_d;
    logic                   hold_phase_q, hold_phase_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    logic                   s_s;
    logic                   enter_press_s;
    logic                   enter_release_s;
    logic                   rpt_run_s;
    logic [RPT_W-1:0]       rpt_last_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s_s    = sync_q[SYNC_STAGES-1];

    // State register: everything freezes while en_i is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            state_q      <= ST_RELEASED;
            db_cnt_q     <= '0;
            rpt_q        <= '0;
            hold_phase_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
        end else if (en_i) begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            rpt_q        <= rpt_d;
            hold_phase_q <= hold_phase_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
        end
    end

    // Next state: db_cnt counts consecutive samples disagreeing with the clean level.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            ST_RELEASED: begin
                if (!s_s) begin
                    db_cnt_d = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else begin
                    state_d  = ST_DB_PRESS;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_DB_PRESS: begin
                if (!s_s) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            ST_PRESSED: begin
                if (s_s) begin
                    db_cnt_d = '0;
                end else if (DEBOUNCE_CYCLES == 1) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = '0;
                end else begin
                    state_d  = ST_DB_RELEASE;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_DB_RELEASE: begin
                if (s_s) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d  = ST_RELEASED;
                db_cnt_d = '0;
            end
        endcase
    end

    assign enter_press_s   = (state_d == ST_PRESSED) &&
                             ((state_q == ST_DB_PRESS) || (state_q == ST_RELEASED));
    assign enter_release_s = (state_d == ST_RELEASED) &&
                             ((state_q == ST_DB_RELEASE) || (state_q == ST_PRESSED));
    assign rpt_run_s       = (state_q == ST_PRESSED) || (state_q == ST_DB_RELEASE);
    assign rpt_last_s      = hold_phase_q ? HOLD_LAST : REP_LAST;

    // Outputs and repeat timer; a repeat tick fires only while staying in PRESSED.
    always_comb begin
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        rpt_d        = rpt_q;
        hold_phase_d = hold_phase_q;
        if (enter_press_s) begin
            level_d      = 1'b1;
            press_d      = 1'b1;
            rpt_d        = '0;
            hold_phase_d = 1'b1;
        end else if (enter_release_s) begin
            level_d      = 1'b0;
            release_d    = 1'b1;
            rpt_d        = '0;
            hold_phase_d = 1'b1;
        end else if (rpt_run_s && (REPEAT_EN != 0)) begin
            if (rpt_q == rpt_last_s) begin
                rpt_d        = '0;
                hold_phase_d = 1'b0;
                press_d      = (state_q == ST_PRESSED) && (state_d == ST_PRESSED);
            end else begin
                rpt_d = rpt_q + RPT_ONE;
            end
        end else begin
            rpt_d = rpt_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent pushbutton channels; ena freezes all state and blanks the pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int REPEAT_EN       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] release_s;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (ena),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (press_s[i]),
            .release_o (release_s[i])
        );
    end

    // Held pulse registers must not re-read as events while frozen.
    assign btn_press   = press_s   & {N_BTN{ena}};
    assign btn_release = release_s & {N_BTN{ena}};

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/repeat timings.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int checks   = 0;
    int failures = 0;

    btn_conditioner #(
        .N_BTN           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3),
        .REPEAT_EN       (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; btn_raw = 4'h0;
        tick(); tick();
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state got=%h expected=000", {btn_level, btn_press, btn_release});
        end
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                failures++;
                $display("FAIL idle cycle=%0d got=%h expected=000", k, {btn_level, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_single_press();
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_press !== ((k == 6) ? 4'b0001 : 4'b0000) ||
                btn_level !== ((k >= 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL single_press cycle=%0d press=%b level=%b expected press=%b level=%b",
                         k, btn_press, btn_level, (k == 6) ? 4'b0001 : 4'b0000, (k >= 6) ? 4'b0001 : 4'b0000);
            end
        end
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_release !== ((k == 6) ? 4'b0001 : 4'b0000) || btn_press !== 4'b0000 ||
                btn_level !== ((k >= 6) ? 4'b0000 : 4'b0001)) begin
                failures++;
                $display("FAIL single_release cycle=%0d release=%b press=%b level=%b expected release=%b press=0000",
                         k, btn_release, btn_press, btn_level, (k == 6) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 7; k++) begin
                btn_raw[1] = (k < 3);
                tick();
                checks++;
                if (btn_level !== 4'b0000 || btn_press !== 4'b0000) begin
                    failures++;
                    $display("FAIL glitch rep=%0d cycle=%0d level=%b press=%b expected 0000", r, k, btn_level, btn_press);
                end
            end
        end
    endtask

    task automatic test_repeat();
        logic exp_p;
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            tick();
            exp_p = (k == 6) || ((k >= 14) && (((k - 14) % 3) == 0));
            checks++;
            if (btn_press !== (exp_p ? 4'b0100 : 4'b0000) ||
                btn_level !== ((k >= 6) ? 4'b0100 : 4'b0000) || btn_release !== 4'b0000) begin
                failures++;
                $display("FAIL repeat cycle=%0d press=%b level=%b release=%b expected press=%b",
                         k, btn_press, btn_level, btn_release, exp_p ? 4'b0100 : 4'b0000);
            end
        end
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_press !== 4'b0000 || btn_release !== ((k == 6) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL repeat_release cycle=%0d press=%b release=%b expected press=0000 release=%b",
                         k, btn_press, btn_release, (k == 6) ? 4'b0100 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        int n_rel;
        int at_rel;
        n_rel = 0; at_rel = 0;
        btn_raw[3] = 1'b1;
        repeat (8) tick();
        for (int j = 1; j <= 18; j++) begin
            btn_raw[3] = (j <= 6) ? ((j % 2) == 0) : 1'b0;
            tick();
            if (btn_release[3] === 1'b1) begin
                n_rel++;
                at_rel = j;
            end
        end
        checks++;
        if (n_rel != 1) begin
            failures++;
            $display("FAIL bounce_count got=%0d expected=1", n_rel);
        end
        checks++;
        if (at_rel != 12) begin
            failures++;
            $display("FAIL bounce_timing got=%0d expected=12", at_rel);
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn_press !== ((k == 6) ? 4'hF : 4'h0) || btn_level !== ((k >= 6) ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL simul_press cycle=%0d press=%h level=%h expected press=%h",
                         k, btn_press, btn_level, (k == 6) ? 4'hF : 4'h0);
            end
        end
        btn_raw = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn_release !== ((k == 6) ? 4'hF : 4'h0) || btn_press !== 4'h0 ||
                btn_level !== ((k >= 6) ? 4'h0 : 4'hF)) begin
                failures++;
                $display("FAIL simul_release cycle=%0d release=%h press=%h level=%h expected release=%h",
                         k, btn_release, btn_press, btn_level, (k == 6) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_ena();
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (btn_press !== ((k == 11) ? 4'b0001 : 4'b0000) ||
                btn_level !== ((k >= 11) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL ena_latency cycle=%0d press=%b level=%b expected press=%b",
                         k, btn_press, btn_level, (k == 11) ? 4'b0001 : 4'b0000);
            end
            if (k == 3) ena = 1'b0;
            if (k == 8) ena = 1'b1;
        end
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn_release !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL ena_release cycle=%0d release=%b expected=%b", k, btn_release, (k == 6) ? 4'b0001 : 4'b0000);
            end
        end
        btn_raw[1] = 1'b1;
        repeat (6) tick();
        ena = 1'b0;
        #1;
        checks++;
        if (btn_press !== 4'b0000 || btn_level !== 4'b0010) begin
            failures++;
            $display("FAIL ena_gate press=%b level=%b expected press=0000 level=0010", btn_press, btn_level);
        end
        tick(); tick();
        ena = 1'b1;
        btn_raw[1] = 1'b0;
        repeat (10) tick();
        checks++;
        if (btn_level !== 4'b0000) begin
            failures++;
            $display("FAIL ena_cleanup level=%b expected=0000", btn_level);
        end
    endtask

    task automatic test_reset_mid_hold();
        btn_raw[2] = 1'b1;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'h000) begin
            failures++;
            $display("FAIL async_reset got=%h expected=000", {btn_level, btn_press, btn_release});
        end
        tick(); tick();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (btn_press !== ((k == 6) ? 4'b0100 : 4'b0000) ||
                btn_level !== ((k >= 6) ? 4'b0100 : 4'b0000) || btn_release !== 4'b0000) begin
                failures++;
                $display("FAIL reset_repress cycle=%0d press=%b level=%b release=%b expected press=%b",
                         k, btn_press, btn_level, btn_release, (k == 6) ? 4'b0100 : 4'b0000);
            end
        end
        btn_raw[2] = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; btn_raw = 4'h0;
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_bounce();
        test_simultaneous();
        test_ena();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
